// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: handshake, decode and control bundle between the controller and its datapath/memory
interface multicycle_ctrl_if;
  logic       start, halt, zero, mem_ready;
  logic [6:0] opcode;
  logic       mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_src, reg_we, retire;
  logic [1:0] aluop, wb_sel;
  logic [3:0] state;
  logic       trap, trap_cause;
  modport master (
    output start, halt, opcode, zero, mem_ready,
    input  mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_src, aluop,
           reg_we, wb_sel, retire, state, trap, trap_cause
  );
  modport slave (
    input  start, halt, opcode, zero, mem_ready,
    output mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_src, aluop,
           reg_we, wb_sel, retire, state, trap, trap_cause
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: IDLE/FETCH/DECODE/EXECUTE/MEM/WRITE_BACK sequencer for a multicycle RV32I subset.
// Defining MC_WATCHDOG_EN adds a memory-wait watchdog that traps after TIMEOUT wait cycles.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic              clk,
  input logic              reset,
  multicycle_ctrl_if.slave bus
);
  typedef enum logic [3:0] {
    IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, EXECUTE = 4'd3,
    WRITE_BACK = 4'd4, MEM = 4'd5, TRAP = 4'd6
  } state_t;
  typedef enum logic [2:0] {C_NONE, C_R, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_ILL} cls_t;
  state_t state_q, boundary_d;
  cls_t   cls_q, cls_d;
  logic   trap_q, cause_q, wd_trip;
  always_comb
    cls_d = bus.opcode == 7'b0110011 ? C_R      :
            bus.opcode == 7'b0010011 ? C_IALU   :
            bus.opcode == 7'b0000011 ? C_LOAD   :
            bus.opcode == 7'b0100011 ? C_STORE  :
            bus.opcode == 7'b1100011 ? C_BRANCH :
            bus.opcode == 7'b1101111 ? C_JAL    : C_ILL;
  assign boundary_d = bus.halt ? IDLE : FETCH;
`ifdef MC_WATCHDOG_EN
  logic [3:0] wd_q;
  logic       waiting;
  assign waiting = (state_q == FETCH || state_q == MEM) && !bus.mem_ready;
  assign wd_trip = waiting && wd_q == 4'(TIMEOUT - 1);
  // Any non-wait cycle (ready, or outside FETCH/MEM) clears it, which also covers entry.
  always_ff @(posedge clk or posedge reset)
    if (reset) wd_q <= '0;
    else       wd_q <= waiting ? wd_q + 4'd1 : '0;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign wd_trip = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cls_q   <= C_NONE;
      trap_q  <= 1'b0;
      cause_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE:       if (bus.start) state_q <= FETCH;
        FETCH:
          if (wd_trip) begin
            state_q <= TRAP;
            trap_q  <= 1'b1;
            cause_q <= 1'b1;
          end else if (bus.mem_ready) state_q <= DECODE;
        DECODE: begin
          cls_q <= cls_d;
          if (cls_d == C_ILL) begin
            state_q <= TRAP;
            trap_q  <= 1'b1;
            cause_q <= 1'b0;
          end else state_q <= EXECUTE;
        end
        EXECUTE:
          state_q <= cls_q == C_BRANCH ? boundary_d :
                     (cls_q == C_LOAD || cls_q == C_STORE) ? MEM : WRITE_BACK;
        MEM:
          if (wd_trip) begin
            state_q <= TRAP;
            trap_q  <= 1'b1;
            cause_q <= 1'b1;
          end else if (bus.mem_ready) state_q <= cls_q == C_LOAD ? WRITE_BACK : boundary_d;
        WRITE_BACK: state_q <= boundary_d;
        TRAP:       ;
        default:    state_q <= IDLE;
      endcase
    end
  logic in_fetch, in_mem, in_exe, in_wb;
  assign in_fetch = state_q == FETCH;
  assign in_mem   = state_q == MEM;
  assign in_exe   = state_q == EXECUTE;
  assign in_wb    = state_q == WRITE_BACK;
  assign bus.mem_req    = in_fetch || in_mem;
  assign bus.mem_we     = in_mem && cls_q == C_STORE;
  assign bus.addr_sel   = in_mem;
  assign bus.ir_we      = in_fetch && bus.mem_ready;
  assign bus.pc_we      = in_exe;
  assign bus.pc_src     = in_exe && (cls_q == C_JAL || (cls_q == C_BRANCH && bus.zero));
  assign bus.alu_src    = in_exe && (cls_q == C_IALU || cls_q == C_LOAD || cls_q == C_STORE);
  assign bus.aluop      = !in_exe ? 2'b00 :
                          (cls_q == C_R || cls_q == C_IALU) ? 2'b10 :
                          cls_q == C_BRANCH ? 2'b01 : 2'b00;
  assign bus.reg_we     = in_wb;
  assign bus.wb_sel     = !in_wb ? 2'b00 : cls_q == C_LOAD ? 2'b01 : cls_q == C_JAL ? 2'b10 : 2'b00;
  assign bus.retire     = in_wb || (in_exe && cls_q == C_BRANCH) ||
                          (in_mem && cls_q == C_STORE && bus.mem_ready);
  assign bus.state      = state_q;
  assign bus.trap       = trap_q;
  assign bus.trap_cause = cause_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed-vector bench for multicycle_ctrl with hand-computed control vectors.
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  multicycle_ctrl_if bus ();
  multicycle_ctrl #(.TIMEOUT(15)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  // {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_src, aluop, reg_we, wb_sel, retire}
  localparam logic [12:0] NONE   = 13'b0_0_0_0_0_0_0_00_0_00_0;
  localparam logic [12:0] F_RDY  = 13'b1_0_0_1_0_0_0_00_0_00_0;
  localparam logic [12:0] F_WAIT = 13'b1_0_0_0_0_0_0_00_0_00_0;
  localparam logic [12:0] EX_R   = 13'b0_0_0_0_1_0_0_10_0_00_0;
  localparam logic [12:0] EX_I   = 13'b0_0_0_0_1_0_1_10_0_00_0;
  localparam logic [12:0] EX_LS  = 13'b0_0_0_0_1_0_1_00_0_00_0;
  localparam logic [12:0] EX_BT  = 13'b0_0_0_0_1_1_0_01_0_00_1;
  localparam logic [12:0] EX_BN  = 13'b0_0_0_0_1_0_0_01_0_00_1;
  localparam logic [12:0] EX_J   = 13'b0_0_0_0_1_1_0_00_0_00_0;
  localparam logic [12:0] MEM_L  = 13'b1_0_1_0_0_0_0_00_0_00_0;
  localparam logic [12:0] MEM_SR = 13'b1_1_1_0_0_0_0_00_0_00_1;
  localparam logic [12:0] WB_A   = 13'b0_0_0_0_0_0_0_00_1_00_1;
  localparam logic [12:0] WB_L   = 13'b0_0_0_0_0_0_0_00_1_01_1;
  localparam logic [12:0] WB_J   = 13'b0_0_0_0_0_0_0_00_1_10_1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic [3:0] st, input logic [12:0] c);
    #1;
    chk({tag, ".state"}, 32'(bus.state), 32'(st));
    chk({tag, ".ctl"}, 32'({bus.mem_req, bus.mem_we, bus.addr_sel, bus.ir_we, bus.pc_we, bus.pc_src,
                           bus.alu_src, bus.aluop, bus.reg_we, bus.wb_sel, bus.retire}), 32'(c));
    @(posedge clk);
    #1;
  endtask
  task automatic fetch_decode(input logic [6:0] op);
    bus.opcode    = op;
    bus.mem_ready = 1'b1;
    cyc("fetch", 4'd1, F_RDY);
    bus.mem_ready = 1'b0;
    cyc("decode", 4'd2, NONE);
  endtask
  task automatic flags(input string tag, input logic t, input logic c);
    chk({tag, ".trap"}, 32'(bus.trap), 32'(t));
    chk({tag, ".cause"}, 32'(bus.trap_cause), 32'(c));
  endtask
  initial begin
    bus.start = 1'b0; bus.halt = 1'b0; bus.zero = 1'b0; bus.mem_ready = 1'b0; bus.opcode = 7'b0;
    repeat (2) @(posedge clk);
    #1;
    flags("reset", 1'b0, 1'b0);
    cyc("reset", 4'd0, NONE);
    reset = 1'b0;
    cyc("idle", 4'd0, NONE);
    bus.start = 1'b1;
    cyc("idle_start", 4'd0, NONE);
    bus.start = 1'b0;
    fetch_decode(7'b0110011);
    cyc("r_exe", 4'd3, EX_R);
    cyc("r_wb", 4'd4, WB_A);
    cyc("r_next", 4'd1, F_WAIT);
    fetch_decode(7'b0000011);
    cyc("ld_exe", 4'd3, EX_LS);
    cyc("ld_mem_w1", 4'd5, MEM_L);
    cyc("ld_mem_w2", 4'd5, MEM_L);
    bus.mem_ready = 1'b1;
    cyc("ld_mem_rdy", 4'd5, MEM_L);
    bus.mem_ready = 1'b0;
    cyc("ld_wb", 4'd4, WB_L);
    bus.zero = 1'b1;
    fetch_decode(7'b1100011);
    cyc("br_taken", 4'd3, EX_BT);
    bus.zero = 1'b0;
    fetch_decode(7'b1100011);
    cyc("br_not", 4'd3, EX_BN);
    bus.zero = 1'b1;
    fetch_decode(7'b0010011);
    cyc("ialu_exe", 4'd3, EX_I);
    cyc("ialu_wb", 4'd4, WB_A);
    bus.zero = 1'b0;
    fetch_decode(7'b1101111);
    cyc("jal_exe", 4'd3, EX_J);
    cyc("jal_wb", 4'd4, WB_J);
    fetch_decode(7'b0100011);
    cyc("st_exe", 4'd3, EX_LS);
    bus.mem_ready = 1'b1;
    bus.halt = 1'b1;
    cyc("st_mem_halt", 4'd5, MEM_SR);
    bus.mem_ready = 1'b0;
    bus.halt = 1'b0;
    cyc("halted", 4'd0, NONE);
    bus.start = 1'b1;
    cyc("restart", 4'd0, NONE);
    bus.start = 1'b0;
    fetch_decode(7'b1111111);
    bus.start = 1'b1;
    bus.mem_ready = 1'b1;
    flags("trap", 1'b1, 1'b0);
    cyc("trap_hold1", 4'd6, NONE);
    cyc("trap_hold2", 4'd6, NONE);
    flags("trap_held", 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("trap_async_rst.state", 32'(bus.state), 32'd0);
    flags("trap_async_rst", 1'b0, 1'b0);
    bus.start = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
`ifdef MC_WATCHDOG_EN
    bus.start = 1'b1;
    cyc("wd_start", 4'd0, NONE);
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) cyc("wd_pre_wait", 4'd1, F_WAIT);
    #2 reset = 1'b1;
    #1;
    chk("wd_midwait_rst.state", 32'(bus.state), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    bus.start = 1'b1;
    cyc("wd_start2", 4'd0, NONE);
    bus.start = 1'b0;
    bus.opcode = 7'b0110011;
    for (int i = 0; i < 14; i++) cyc("wd_wait14", 4'd1, F_WAIT);
    fetch_decode(7'b0110011);
    cyc("wd_r_exe", 4'd3, EX_R);
    cyc("wd_r_wb", 4'd4, WB_A);
    for (int i = 0; i < 15; i++) cyc("wd_wait15", 4'd1, F_WAIT);
    #1;
    chk("wd_trap.state", 32'(bus.state), 32'd6);
    chk("wd_trap.mem_req", 32'(bus.mem_req), 32'd0);
    flags("wd_trap", 1'b1, 1'b1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
